// File: rtl/dskw_pkg.sv
// Shared types and geometry for the host-side deskew frame controller.
// Frame geometry and BRAM layout defaults live here so every user agrees on them.
package dskw_pkg;

  localparam int PIXELS        = 784;
  localparam int IMG_DIM       = 28;
  localparam int DSKW_IN_BASE  = 0;
  localparam int DSKW_OUT_BASE = 784;
  localparam int BRAM_ADDR_W   = 11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_DONE,
    S_RD_ADDR,
    S_RD_WAIT,
    S_SEND
  } dskw_frame_state_t;

endpackage

// File: rtl/dskw_frame_ctrl.sv
// Host-side controller for the shared deskew BRAM (port A): loads a raw frame,
// kicks the Deskew core, then streams the deskewed frame back out.
module dskw_frame_ctrl #(
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = dskw_pkg::BRAM_ADDR_W,
  parameter int PIXELS   = dskw_pkg::PIXELS,
  parameter int IN_BASE  = dskw_pkg::DSKW_IN_BASE,
  parameter int OUT_BASE = dskw_pkg::DSKW_OUT_BASE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_pixel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_pixel,
  output logic              out_last,
  output logic              dskw_start,
  input  logic              dskw_ready,
  output logic [ADDR_W-1:0] bram_address,
  output logic [WIDTH-1:0]  bram_out_data,
  input  logic [WIDTH-1:0]  bram_in_data,
  output logic              bram_en,
  output logic              bram_we,
  output logic              busy,
  output logic              frame_done
);
  import dskw_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_CNT   = ADDR_W'(PIXELS - 1);
  localparam logic [ADDR_W-1:0] IN_BASE_A  = ADDR_W'(IN_BASE);
  localparam logic [ADDR_W-1:0] OUT_BASE_A = ADDR_W'(OUT_BASE);

  // Both image regions must fit in the BRAM and must not overlap.
  if ((IN_BASE + PIXELS > (1 << ADDR_W)) || (OUT_BASE + PIXELS > (1 << ADDR_W)) ||
      ((IN_BASE < OUT_BASE + PIXELS) && (OUT_BASE < IN_BASE + PIXELS))) begin : g_bad_params
    $error("dskw_frame_ctrl: illegal BRAM layout parameters");
  end

  dskw_frame_state_t state;
  logic [ADDR_W-1:0] cnt;
  logic              load_hs;

  // Valid/ready: a beat transfers on a rising edge where valid and ready are both
  // high; a source holds valid and data stable until that edge.
  assign load_hs    = (state == S_LOAD) && in_valid && !reset;
  assign in_ready   = (state == S_LOAD);
  assign dskw_start = (state == S_START);
  assign busy       = (state != S_IDLE);

  always_comb begin
    bram_en       = 1'b0;
    bram_we       = 1'b0;
    bram_address  = '0;
    bram_out_data = '0;
    if (load_hs) begin
      bram_en       = 1'b1;
      bram_we       = 1'b1;
      bram_address  = IN_BASE_A + cnt;
      bram_out_data = in_pixel;
    end else if (state == S_RD_ADDR) begin
      bram_en      = 1'b1;
      bram_address = OUT_BASE_A + cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_pixel  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          // The pixel that wakes us is accepted later, in LOAD.
          if (in_valid) state <= S_LOAD;
        end
        S_LOAD: begin
          if (load_hs) begin
            if (cnt == LAST_CNT) begin
              cnt   <= '0;
              state <= S_START;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_START: begin
          if (!dskw_ready) state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (dskw_ready) state <= S_RD_ADDR;
        end
        S_RD_ADDR: begin
          state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          out_pixel <= bram_in_data;
          out_valid <= 1'b1;
          out_last  <= (cnt == LAST_CNT);
          state     <= S_SEND;
        end
        S_SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (cnt == LAST_CNT) begin
              cnt        <= '0;
              frame_done <= 1'b1;
              state      <= S_IDLE;
            end else begin
              cnt   <= cnt + 1'b1;
              state <= S_RD_ADDR;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dskw_frame_ctrl.sv
// Bench for dskw_frame_ctrl: dual-port BRAM model plus a stub Deskew core that
// mirrors each row and XORs a constant into the output region.
module tb_dskw_frame_ctrl;

  localparam int PIX    = 784;
  localparam int IMG    = 28;
  localparam int OUT_B  = 784;
  localparam int LIMIT  = 20000;
  localparam logic [15:0] XMASK = 16'h5A5A;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_pixel = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_pixel;
  logic        out_last;
  logic        dskw_start;
  logic        dskw_ready = 1'b1;
  logic [10:0] bram_address;
  logic [15:0] bram_out_data;
  logic [15:0] bram_in_data;
  logic        bram_en;
  logic        bram_we;
  logic        busy;
  logic        frame_done;

  dskw_frame_ctrl dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel), .out_last(out_last),
    .dskw_start(dskw_start), .dskw_ready(dskw_ready),
    .bram_address(bram_address), .bram_out_data(bram_out_data), .bram_in_data(bram_in_data),
    .bram_en(bram_en), .bram_we(bram_we), .busy(busy), .frame_done(frame_done)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- BRAM model + Deskew stub ----------------
  logic [15:0] mem [0:2047];
  logic [15:0] rd_q = '0;
  int stub_drop = 2;
  int stub_run  = 5;
  int stub_st = 0, sc = 0, rc = 0;
  assign bram_in_data = rd_q;

  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) mem[bram_address] <= bram_out_data;
      rd_q <= mem[bram_address];
    end
    if (stub_st == 0) begin
      if (dskw_start) begin
        sc = sc + 1;
        if (sc >= stub_drop - 1) begin
          dskw_ready <= 1'b0;
          stub_st = 1;
          sc = 0;
          rc = 0;
        end
      end
    end else begin
      rc = rc + 1;
      if (rc >= stub_run) begin
        for (int r = 0; r < IMG; r++)
          for (int c = 0; c < IMG; c++)
            mem[OUT_B + r * IMG + (IMG - 1 - c)] <= mem[r * IMG + c] ^ XMASK;
        dskw_ready <= 1'b1;
        stub_st = 0;
      end
    end
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] frame_pix [PIX];

  int wr_cnt, wr_bad, wr_novalid, beat_idx, frame_fd, start_cyc;
  int rise_cyc, first_rd_cyc, first_rd_addr, busy_bad, rb_inready_bad;
  int fd_cnt = 0;
  bit rd_phase, stall_prev, ready_prev = 1'b1;
  logic [15:0] prev_pix;
  logic prev_last;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    wr_cnt = 0; wr_bad = 0; wr_novalid = 0; beat_idx = 0; frame_fd = 0; start_cyc = 0;
    rise_cyc = -1; first_rd_cyc = -1; first_rd_addr = -1; busy_bad = 0; rb_inready_bad = 0;
    rd_phase = 0; stall_prev = 0;
    exp_q.delete();
  endtask

  // ---------------- monitor (samples on the falling edge) ----------------
  always @(negedge clk) begin
    if (bram_en && bram_we) begin
      if (int'(bram_address) != wr_cnt || wr_cnt >= PIX || bram_out_data != frame_pix[wr_cnt])
        wr_bad++;
      if (!(in_valid && in_ready)) wr_novalid++;
      wr_cnt++;
    end
    if (stall_prev)
      chk("stall_stable", {15'd0, out_valid, out_last, out_pixel}, {15'd0, 1'b1, prev_last, prev_pix});
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("beat_extra", 32'(beat_idx), 32'(PIX));
      else chk("beat_pix", {16'd0, out_pixel}, {16'd0, exp_q.pop_front()});
      chk("beat_last", {31'd0, out_last}, {31'd0, beat_idx == PIX - 1});
      beat_idx++;
    end
    stall_prev = out_valid && !out_ready;
    prev_pix   = out_pixel;
    prev_last  = out_last;
    if (dskw_start) begin
      start_cyc++;
      rd_phase = 1;
    end
    if (dskw_ready && !ready_prev && rise_cyc < 0) rise_cyc = cyc;
    ready_prev = dskw_ready;
    if (bram_en && !bram_we && first_rd_cyc < 0) begin
      first_rd_cyc  = cyc;
      first_rd_addr = int'(bram_address);
    end
    if ((in_ready || out_valid || dskw_start || bram_en) && !busy) busy_bad++;
    if (rd_phase && in_ready) rb_inready_bad++;
    if (frame_done) begin
      fd_cnt++;
      frame_fd++;
      rd_phase = 0;
    end
  end

  // ---------------- drivers ----------------
  task automatic drive_frame(input int gap, input int npix, input bit hold);
    int i = 0;
    int k = 0;
    while (i < npix && k < LIMIT) begin
      @(posedge clk); #1;
      case (gap)
        0: in_valid = 1'b1;
        1: in_valid = (k % 2 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_pixel = frame_pix[i];
      @(negedge clk);
      if (in_valid && in_ready) i++;
      k++;
    end
    if (i < npix) chk("load_timeout", 32'(i), 32'(npix));
    @(posedge clk); #1;
    in_valid = hold;
    in_pixel = 16'hDEAD;
    if (hold) begin
      for (int g = 0; g < LIMIT; g++) begin
        @(negedge clk);
        if (out_valid && out_ready && out_last) break;
      end
      in_valid = 1'b0;
    end
  endtask

  task automatic receive(input int omode);
    int fd0 = fd_cnt;
    int c = 0;
    while (fd_cnt == fd0 && c < LIMIT) begin
      @(posedge clk); #1;
      case (omode)
        0: out_ready = 1'b1;
        1: out_ready = (c % 4 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      c++;
    end
    if (fd_cnt == fd0) chk("frame_timeout", 32'(c), 32'(0));
    out_ready = 1'b1;
  endtask

  task automatic new_frame();
    clear_logs();
    for (int i = 0; i < PIX; i++) frame_pix[i] = 16'($urandom);
    // Reference: each row mirrored left-to-right, constant XORed in.
    for (int p = 0; p < PIX; p++) begin
      int r = p / IMG;
      int c = p % IMG;
      exp_q.push_back(frame_pix[r * IMG + (IMG - 1 - c)] ^ XMASK);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"},   {31'd0, in_ready},   32'd0);
    chk({tag, "_out_valid"},  {31'd0, out_valid},  32'd0);
    chk({tag, "_out_last"},   {31'd0, out_last},   32'd0);
    chk({tag, "_dskw_start"}, {31'd0, dskw_start}, 32'd0);
    chk({tag, "_bram_en"},    {31'd0, bram_en},    32'd0);
    chk({tag, "_bram_we"},    {31'd0, bram_we},    32'd0);
    chk({tag, "_bram_addr"},  {21'd0, bram_address}, 32'd0);
    chk({tag, "_busy"},       {31'd0, busy},       32'd0);
    chk({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
  endtask

  typedef struct {
    int gap;          // 0 continuous, 1 every other cycle, 2 random
    int omode;        // 0 always ready, 1 one-on three-off, 2 random
    int drop;         // stub: start cycles before ready falls
    int run;          // stub: busy cycles
    bit hold;         // keep in_valid high during readback
    int exp_start;    // expected dskw_start high cycles
    int exp_writes;
    int exp_beats;
    int exp_rd_addr;
    int exp_rd_delay; // cycles from ready rise to first read
  } scen_t;

  task automatic run_frame(input scen_t s, input string tag);
    int bad_mem = 0;
    stub_drop = s.drop;
    stub_run  = s.run;
    new_frame();
    fork
      drive_frame(s.gap, PIX, s.hold);
      receive(s.omode);
    join
    repeat (3) @(negedge clk);
    for (int i = 0; i < PIX; i++) if (mem[i] != frame_pix[i]) bad_mem++;
    chk({tag, "_writes"},       32'(wr_cnt),       32'(s.exp_writes));
    chk({tag, "_write_bad"},    32'(wr_bad),       32'd0);
    chk({tag, "_write_novld"},  32'(wr_novalid),   32'd0);
    chk({tag, "_beats"},        32'(beat_idx),     32'(s.exp_beats));
    chk({tag, "_exp_left"},     32'(exp_q.size()), 32'd0);
    chk({tag, "_frame_done"},   32'(frame_fd),     32'd1);
    chk({tag, "_start_cyc"},    32'(start_cyc),    32'(s.exp_start));
    chk({tag, "_rd_delay"},     32'(first_rd_cyc - rise_cyc), 32'(s.exp_rd_delay));
    chk({tag, "_rd_addr"},      32'(first_rd_addr), 32'(s.exp_rd_addr));
    chk({tag, "_busy_bad"},     32'(busy_bad),     32'd0);
    chk({tag, "_rb_in_ready"},  32'(rb_inready_bad), 32'd0);
    chk({tag, "_bram_in_kept"}, 32'(bad_mem),      32'd0);
    chk({tag, "_idle_busy"},    {31'd0, busy},     32'd0);
  endtask

  scen_t tab [4];

  initial begin
    tab[0] = '{gap: 0, omode: 0, drop: 2, run: 5,  hold: 0, exp_start: 2,
               exp_writes: PIX, exp_beats: PIX, exp_rd_addr: OUT_B, exp_rd_delay: 1};
    tab[1] = '{gap: 0, omode: 1, drop: 2, run: 3,  hold: 0, exp_start: 2,
               exp_writes: PIX, exp_beats: PIX, exp_rd_addr: OUT_B, exp_rd_delay: 1};
    tab[2] = '{gap: 1, omode: 0, drop: 4, run: 20, hold: 0, exp_start: 4,
               exp_writes: PIX, exp_beats: PIX, exp_rd_addr: OUT_B, exp_rd_delay: 1};
    tab[3] = '{gap: 2, omode: 2, drop: 3, run: 8,  hold: 1, exp_start: 3,
               exp_writes: PIX, exp_beats: PIX, exp_rd_addr: OUT_B, exp_rd_delay: 1};

    clear_logs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("por");
    @(posedge clk); #1;
    reset = 1'b0;

    for (int k = 0; k < 4; k++) run_frame(tab[k], $sformatf("scen%0d", k));

    // Abort a load after 300 pixels, then a clean frame must behave normally.
    new_frame();
    drive_frame(0, 300, 1'b0);
    chk("abort_writes", 32'(wr_cnt), 32'd300);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset("abort");
    @(posedge clk); #1;
    reset = 1'b0;
    run_frame(tab[0], "post_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
